// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: PC operation encoding and reset address default.
package cpu_pkg;

    typedef enum logic [2:0] {
        INC    = 3'd0,
        JUMP   = 3'd1,
        BRANCH = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4
    } pc_op_t;

    localparam int unsigned RESET_ADDR_DEF = 0;

endpackage

// File: rtl/pc_unit_if.sv
// Control-unit <-> program-counter bundle: op request in, fetch address and RAS status out.
interface pc_unit_if #(
    parameter int ADDR_W    = 9,
    parameter int OFF_W     = 6,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic              stall;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic [OFF_W-1:0]  offset;
    logic              cond;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W-1:0] link;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_err;

    modport master (
        output stall, op, target, offset, cond,
        input  address, link, ras_count, ras_err
    );

    modport slave (
        input  stall, op, target, offset, cond,
        output address, link, ras_count, ras_err
    );
endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry, an empty pop is ignored.
// overflow/underflow are combinational flags on the offending request.
module ras_stack #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_dat,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic             full;
    logic             empty;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign overflow  = push && full;
    assign underflow = pop && empty;
    assign top_ptr   = wr_ptr - 1'b1;
    assign top       = empty ? '0 : mem[top_ptr];

    // wr_ptr always names the next free slot; when full that slot is the oldest entry
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!full)
                count <= count + 1'b1;
        end else if (pop && !empty) begin
            wr_ptr <= top_ptr;
            count  <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential/jump/branch/call/return with an internal RAS.
// New address one cycle after op; stall freezes all state and masks ras_err.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W     = 9,
    parameter int          OFF_W      = 6,
    parameter int          STEP       = 1,
    parameter int          RAS_DEPTH  = 4,
    parameter int unsigned RESET_ADDR = RESET_ADDR_DEF
) (
    input  logic     clk,
    input  logic     reset,
    pc_unit_if.slave pc
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [ADDR_W-1:0] address_q;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] rel_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] ras_top;
    logic [CNT_W-1:0]  ras_cnt;
    logic              push;
    logic              pop;
    logic              overflow;
    logic              underflow;
    logic              ras_err_q;

    assign seq_addr = address_q + ADDR_W'(STEP);
    assign rel_addr = address_q + {{(ADDR_W-OFF_W){pc.offset[OFF_W-1]}}, pc.offset};

    always_comb begin
        next_addr = seq_addr;
        push      = 1'b0;
        pop       = 1'b0;
        case (pc.op)
            JUMP:   next_addr = pc.target;
            BRANCH: if (pc.cond) next_addr = rel_addr;
            CALL: begin
                push      = !pc.stall;
                next_addr = pc.target;
            end
            RET: begin
                pop = !pc.stall;
                if (ras_cnt != '0) next_addr = ras_top;
            end
            default: ;
        endcase
    end

    ras_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_dat  (seq_addr),
        .top       (ras_top),
        .count     (ras_cnt),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            address_q <= ADDR_W'(RESET_ADDR);
            ras_err_q <= 1'b0;
        end else if (pc.stall) begin
            ras_err_q <= 1'b0;
        end else begin
            address_q <= next_addr;
            ras_err_q <= overflow || underflow;
        end
    end

    assign pc.address   = address_q;
    assign pc.link      = ras_top;
    assign pc.ras_count = ras_cnt;
    assign pc.ras_err   = ras_err_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed plus random checks of pc_unit against a queue-based PC/RAS reference model.
module tb_pc_unit;
    localparam int ADDR_W = 9;
    localparam int OFF_W  = 6;
    localparam int DEPTH  = 4;
    localparam int AMOD   = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;

    int n_vec = 0;
    int n_err = 0;

    int m_addr;
    int m_ras[$];
    int m_err;

    always #5 clk = ~clk;

    pc_unit_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .RAS_DEPTH(DEPTH)) bus ();

    pc_unit #(
        .ADDR_W     (ADDR_W),
        .OFF_W      (OFF_W),
        .STEP       (1),
        .RAS_DEPTH  (DEPTH),
        .RESET_ADDR (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pc    (bus.slave)
    );

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: ops applied to an integer address and a bounded queue of return addresses
    task automatic model(input int rst, input int stl, input int op, input int tgt,
                         input int off, input int c);
        int soff;
        m_err = 0;
        soff  = (off >= (1 << (OFF_W - 1))) ? off - (1 << OFF_W) : off;
        if (rst != 0) begin
            m_addr = 0;
            m_ras.delete();
        end else if (stl == 0) begin
            case (op)
                1: m_addr = tgt;
                2: m_addr = (c != 0) ? (m_addr + soff + AMOD) % AMOD : (m_addr + 1) % AMOD;
                3: begin
                    m_ras.push_back((m_addr + 1) % AMOD);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_front());
                        m_err = 1;
                    end
                    m_addr = tgt;
                end
                4: begin
                    if (m_ras.size() == 0) begin
                        m_err  = 1;
                        m_addr = (m_addr + 1) % AMOD;
                    end else begin
                        m_addr = m_ras.pop_back();
                    end
                end
                default: m_addr = (m_addr + 1) % AMOD;
            endcase
        end
    endtask

    task automatic apply(input string tag, input int rst, input int stl, input int op,
                         input int tgt, input int off, input int c);
        reset      = rst[0];
        bus.stall  = stl[0];
        bus.op     = op[2:0];
        bus.target = tgt[ADDR_W-1:0];
        bus.offset = off[OFF_W-1:0];
        bus.cond   = c[0];
        @(posedge clk);
        model(rst, stl, op, tgt, off, c);
        #1;
        cmp({tag, ".address"}, 32'(bus.address), 32'(m_addr));
        cmp({tag, ".ras_count"}, 32'(bus.ras_count), 32'(m_ras.size()));
        cmp({tag, ".link"}, 32'(bus.link), (m_ras.size() > 0) ? 32'(m_ras[$]) : 32'd0);
        cmp({tag, ".ras_err"}, 32'(bus.ras_err), 32'(m_err));
    endtask

    initial begin
        m_addr     = 0;
        reset      = 1'b1;
        bus.stall  = 1'b0;
        bus.op     = 3'd0;
        bus.target = '0;
        bus.offset = '0;
        bus.cond   = 1'b0;

        apply("reset0", 1, 0, 0, 0, 0, 0);
        apply("reset1", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply("inc", 0, 0, 0, 0, 0, 0);
        cmp("inc3_const", 32'(bus.address), 32'h003);

        apply("jump1ff", 0, 0, 1, 'h1FF, 0, 0);
        apply("wrap", 0, 0, 0, 0, 0, 0);
        cmp("wrap_const", 32'(bus.address), 32'h000);

        apply("jump010", 0, 0, 1, 'h010, 0, 0);
        apply("br_taken", 0, 0, 2, 0, 'h3C, 1);
        cmp("br_taken_const", 32'(bus.address), 32'h00C);
        apply("br_not", 0, 0, 2, 0, 'h3C, 0);
        apply("jump002", 0, 0, 1, 'h002, 0, 0);
        apply("br_neg_wrap", 0, 0, 2, 0, 'h3C, 1);
        cmp("br_neg_wrap_const", 32'(bus.address), 32'h1FE);

        apply("jump020", 0, 0, 1, 'h020, 0, 0);
        apply("call100", 0, 0, 3, 'h100, 0, 0);
        cmp("call_link_const", 32'(bus.link), 32'h021);
        apply("ret", 0, 0, 4, 0, 0, 0);

        apply("jump010b", 0, 0, 1, 'h010, 0, 0);
        for (int i = 2; i <= 6; i++) apply("nest_call", 0, 0, 3, i * 'h10, 0, 0);
        cmp("overflow_pulse", 32'(bus.ras_err), 32'd1);
        for (int i = 0; i < 4; i++) apply("nest_ret", 0, 0, 4, 0, 0, 0);
        cmp("last_ret_const", 32'(bus.address), 32'h021);
        apply("underflow", 0, 0, 4, 0, 0, 0);
        apply("after_underflow", 0, 0, 0, 0, 0, 0);

        apply("pre_stall_call", 0, 0, 3, 'h140, 0, 0);
        apply("stall_jump", 0, 1, 1, 'h0AA, 0, 0);
        apply("stall_jump2", 0, 1, 1, 'h0AA, 0, 0);
        cmp("stall_hold_const", 32'(bus.address), 32'h140);
        apply("stall_ret", 0, 1, 4, 0, 0, 0);
        apply("unstall_ret", 0, 0, 4, 0, 0, 0);
        apply("pre_rst_call", 0, 0, 3, 'h0F0, 0, 0);
        apply("rst_stall_call", 1, 1, 3, 'h100, 0, 0);
        cmp("rst_count_const", 32'(bus.ras_count), 32'd0);

        for (int i = 0; i < 400; i++) begin
            int op_r;
            op_r = ($urandom_range(0, 9) < 3) ? 3 : ($urandom_range(0, 3) == 0 ? 4 : int'($urandom_range(0, 7)));
            apply("rand",
                  ($urandom_range(0, 63) == 0) ? 1 : 0,
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  op_r,
                  int'($urandom_range(0, AMOD - 1)),
                  int'($urandom_range(0, (1 << OFF_W) - 1)),
                  int'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the CPU fetch stage. It generalises the basic load/increment PC with configurable width and step, PC-relative conditional branches, stall, and call/return through an internal circular return-address stack (RAS). Each cycle it produces the fetch address and reports RAS overflow/underflow to the control unit.

## Interface
Parameters:
- ADDR_W, 9, address width in bits; all address arithmetic is modulo 2^ADDR_W.
- OFF_W, 6, width of the signed branch offset.
- STEP, 1, increment applied for sequential flow.
- RAS_DEPTH, 4, number of return-address entries (≥2, power of two).
- RESET_ADDR, 0, address loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all state this cycle.
- op  in  3  operation select (package encoding below).
- target  in  ADDR_W  absolute destination for JUMP/CALL.
- offset  in  OFF_W  signed two's-complement branch displacement.
- cond  in  1  branch-taken qualifier for BRANCH.
- address  out  ADDR_W  current fetch address (registered).
- link  out  ADDR_W  top RAS entry (0 when empty).
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_err  out  1  one-cycle pulse on RAS overflow or underflow.

## Operation
- op encoding: INC=0, JUMP=1, BRANCH=2, CALL=3, RET=4; codes 5–7 behave as INC.
- INC: address ← address+STEP.
- JUMP: address ← target.
- BRANCH: cond=1 → address ← address + sign-extended offset; cond=0 → address+STEP.
- CALL: push address+STEP, address ← target. If full: overwrite oldest entry (circular), ras_count stays RAS_DEPTH, ras_err=1.
- RET: non-empty → address ← top, pop. Empty → address+STEP, count stays 0, ras_err=1.
- stall=1: address, RAS, and ras_count unchanged regardless of op; ras_err=0.
- All sums truncate to ADDR_W bits, e.g. 0x1FF+1 → 0x000.
- reset=1 overrides stall and op: address=RESET_ADDR, ras_count=0, link=0, ras_err=0. RAS contents are don't-care after reset.

## Timing
- Next-address logic is combinational from current inputs and state. address, ras_count, and ras_err update on the same edge, giving one-cycle latency from op to new address.
- link is combinational from stack pointer and storage, so it reflects state after the last edge.
- A CALL followed immediately by RET returns on the second edge to the pushed address, with no bypass hazard.
- Reset asserted mid-sequence takes effect at the next edge. Pending push/pop in that cycle is discarded.

## Structure
- cpu_pkg: pc_op_t enum (INC/JUMP/BRANCH/CALL/RET) and the RESET_ADDR default constant.
- Sub-module ras_stack (params WIDTH, DEPTH): push, pop, top, count, overflow, underflow. Implemented as a circular buffer with a wrapping pointer.
- pc_unit holds next-address mux, address register, and ras_err register.

## Test plan
- Reset high 2 cycles, then INC ×3 → address 0x000, 0x001, 0x002, 0x003. ras_count=0, link=0.
- JUMP target=0x1FF, then INC → address 0x1FF, then 0x000 (wrap).
- Branch cases:
  - At 0x010, BRANCH offset=-4, cond=1 → 0x00C.
  - At 0x00C, cond=0 → 0x00D.
  - At 0x002, offset=-4, cond=1 → 0x1FE.
- At 0x020, CALL target=0x100 → address 0x100, link 0x021, ras_count 1. Then RET → 0x021, ras_count 0, no ras_err.
- Five nested CALLs from 0x010/0x020/0x030/0x040/0x050 (RAS_DEPTH=4):
  - Fifth call → ras_err pulse, ras_count 4.
  - RETs ×4 → 0x051, 0x041, 0x031, 0x021.
  - Fifth RET → ras_err, address+1.
- Stall and reset:
  - stall=1 with op=JUMP target=0x0AA → address and ras_count unchanged for the stalled cycles.
  - reset=1 together with stall=1 and CALL → address 0x000, ras_count 0.
